// File: rtl/mem_burst_responder.sv
// Memory-conduit responder backed by an on-chip 16-bit word RAM.
// One rd/wr command in, one 8-word wrapped burst out, with SDRAM-like latency and recovery.
module mem_burst_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int CAS_LATENCY = 3,
    parameter int RECOVERY    = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [22:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  dm_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [15:0] dat_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATENCY,
        S_BURST,
        S_RECOVER
    } state_t;

    localparam logic [2:0] CAS_M1 = 3'(CAS_LATENCY - 1);
    localparam logic [2:0] REC_M1 = (RECOVERY > 0) ? 3'(RECOVERY - 1) : 3'd0;

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic [2:0]             r_idx;
    logic                   r_is_wr;
    logic [ADDR_BITS-1:0]   r_adr;
    logic                   r_busy;
    logic                   r_valid;
    logic [15:0]            r_dat;
    logic [15:0]            r_mem [2**ADDR_BITS];

    logic [2:0]             w_rd_idx;
    logic [2:0]             w_rd_lo;
    logic [2:0]             w_wr_lo;
    logic [ADDR_BITS-1:0]   w_rd_addr;
    logic [ADDR_BITS-1:0]   w_wr_addr;
    logic                   w_wr_en;
    logic                   w_unused;

    // Read address runs one word ahead of the burst index so dat_o is ready as each beat starts.
    assign w_rd_idx  = (r_state == S_BURST) ? r_idx + 3'd1 : 3'd0;
    assign w_rd_lo   = r_adr[2:0] + w_rd_idx;
    assign w_wr_lo   = r_adr[2:0] + r_idx;
    assign w_rd_addr = {r_adr[ADDR_BITS-1:3], w_rd_lo};
    assign w_wr_addr = {r_adr[ADDR_BITS-1:3], w_wr_lo};
    assign w_wr_en   = (r_state == S_BURST) && r_is_wr;
    assign w_unused  = ^adr_i[22:ADDR_BITS];

    // NOTE: the RAM array has no reset; contents must survive reset, and a reset
    // port would prevent mapping onto block RAM.
    always_ff @(posedge clock_i) begin
        if (w_wr_en) begin
            if (!dm_i[0]) r_mem[w_wr_addr][7:0]  <= dat_i[7:0];
            if (!dm_i[1]) r_mem[w_wr_addr][15:8] <= dat_i[15:8];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_idx   <= 3'd0;
            r_is_wr <= 1'b0;
            r_adr   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dat   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i && (rd_i || wr_i)) begin
                        r_adr   <= adr_i[ADDR_BITS-1:0];
                        r_is_wr <= !rd_i;
                        r_cnt   <= CAS_M1;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_LATENCY;
                    end
                end
                S_LATENCY: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_BURST;
                        r_valid <= 1'b1;
                        r_idx   <= 3'd0;
                        if (!r_is_wr) r_dat <= r_mem[w_rd_addr];
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_BURST: begin
                    if (r_idx == 3'd7) begin
                        r_valid <= 1'b0;
                        r_dat   <= 16'h0000;
                        if (RECOVERY == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_RECOVER;
                            r_cnt   <= REC_M1;
                        end
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        if (!r_is_wr) r_dat <= r_mem[w_rd_addr];
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign valid_o = r_valid;
    assign dat_o   = r_dat;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: a word-level RAM model feeds a queue of
// expected read beats, popped and compared as valid_o beats appear.
module tb_mem_burst_responder;

    localparam int CAS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, enable2;
    logic        rd, wr;
    logic [22:0] adr;
    logic [15:0] dat_in;
    logic [1:0]  dm;
    logic        busy, valid;
    logic [15:0] dat_out;
    logic        busy2, valid2;
    logic [15:0] dat_out2;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model [1024];
    logic [15:0] exp_q [$];
    logic [15:0] wdat [8];
    logic [1:0]  wdm  [8];

    always #5 clk = ~clk;

    mem_burst_responder u_dut (
        .clock_i(clk), .reset_i(reset), .enable_i(enable), .rd_i(rd), .wr_i(wr),
        .adr_i(adr), .dat_i(dat_in), .dm_i(dm),
        .busy_o(busy), .valid_o(valid), .dat_o(dat_out)
    );

    mem_burst_responder #(.CAS_LATENCY(1), .RECOVERY(0)) u_dut_fast (
        .clock_i(clk), .reset_i(reset), .enable_i(enable2), .rd_i(rd), .wr_i(wr),
        .adr_i(adr), .dat_i(dat_in), .dm_i(dm),
        .busy_o(busy2), .valid_o(valid2), .dat_o(dat_out2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] word_addr(input logic [22:0] a, input int k);
        logic [2:0] lo;
        lo = a[2:0] + 3'(k);
        return {a[9:3], lo};
    endfunction

    function automatic void model_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] m);
        if (!m[0]) model[a][7:0]  = d[7:0];
        if (!m[1]) model[a][15:8] = d[15:8];
    endfunction

    // One complete command on the CAS=3/RECOVERY=1 instance.
    // pulse_k: beat at which a stray read command is strobed (-1 = none).
    // abort_k: beat during which reset is asserted mid-cycle (-1 = none).
    task automatic burst(input bit r, input bit w, input logic [22:0] a,
                         input int pulse_k, input int abort_k);
        int n;
        logic [15:0] e;
        if (r) for (int k = 0; k < 8; k++) exp_q.push_back(model[word_addr(a, k)]);
        enable = 1'b1; rd = r; wr = w; adr = a;
        tick;
        enable = 1'b0; rd = 1'b0; wr = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("valid_low_at_accept", {31'd0, valid}, 32'd0);
        n = 0;
        while (!valid && n < 20) begin
            tick;
            n++;
        end
        check("cas_latency", n, CAS);
        for (int k = 0; k < 8; k++) begin
            check("valid_beat", {31'd0, valid}, 32'd1);
            if (r) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("rd_data", {16'd0, dat_out}, {16'd0, e});
            end else begin
                check("wr_dat_o_zero", {16'd0, dat_out}, 32'd0);
                dat_in = wdat[k];
                dm     = wdm[k];
            end
            if (k == pulse_k) begin
                enable = 1'b1;
                rd     = 1'b1;
            end
            if (k == abort_k) begin
                #3 reset = 1'b1;
                #1;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_valid", {31'd0, valid}, 32'd0);
                check("abort_dat", {16'd0, dat_out}, 32'd0);
                tick;
                tick;
                reset = 1'b0;
                tick;
                check("post_reset_idle", {31'd0, busy}, 32'd0);
                return;
            end
            if (!r) model_write(word_addr(a, k), wdat[k], wdm[k]);
            tick;
            enable = 1'b0;
            rd     = 1'b0;
        end
        check("valid_fall", {31'd0, valid}, 32'd0);
        check("dat_idle_zero", {16'd0, dat_out}, 32'd0);
        check("busy_recover", {31'd0, busy}, 32'd1);
        tick;
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; enable2 = 1'b0; rd = 1'b0; wr = 1'b0;
        adr = '0; dat_in = '0; dm = 2'b00;
        for (int i = 0; i < 1024; i++) model[i] = 16'hxxxx;
        tick;
        tick;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_dat", {16'd0, dat_out}, 32'd0);
        reset = 1'b0;
        tick;

        // Full write then readback at the aligned block 0x10
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'h1111 * 16'(k + 1);
            wdm[k]  = 2'b00;
        end
        burst(1'b0, 1'b1, 23'h000010, -1, -1);
        burst(1'b1, 1'b0, 23'h000010, -1, -1);

        // Wrapped read from 0x15, with a stray command strobed mid-burst
        burst(1'b1, 1'b0, 23'h000015, 2, -1);
        check("stray_cmd_ignored", {31'd0, busy}, 32'd0);

        // Byte mask: low byte masked on word 0; fully masked on the rest
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'hABCD;
            wdm[k]  = (k == 0) ? 2'b01 : 2'b11;
        end
        burst(1'b0, 1'b1, 23'h000010, -1, -1);
        burst(1'b1, 1'b0, 23'h000010, -1, -1);
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'hFFFF;
            wdm[k]  = 2'b11;
        end
        burst(1'b0, 1'b1, 23'h000010, -1, -1);
        burst(1'b1, 1'b0, 23'h000010, -1, -1);

        // rd and wr both set: read wins, RAM untouched
        burst(1'b1, 1'b1, 23'h000010, -1, -1);
        burst(1'b1, 1'b0, 23'h000010, -1, -1);

        // enable without a command qualifier
        enable = 1'b1;
        tick;
        check("no_cmd_busy", {31'd0, busy}, 32'd0);
        tick;
        check("no_cmd_busy_2", {31'd0, busy}, 32'd0);
        enable = 1'b0;
        tick;

        // Aliasing above ADDR_BITS
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'hA000 + 16'(k);
            wdm[k]  = 2'b00;
        end
        burst(1'b0, 1'b1, 23'h000400, -1, -1);
        burst(1'b1, 1'b0, 23'h000000, -1, -1);

        // Reset during write beat 3: beats 0..2 land, 3..7 keep old data
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'hC000 + 16'(k);
            wdm[k]  = 2'b00;
        end
        burst(1'b0, 1'b1, 23'h000010, -1, 3);
        burst(1'b1, 1'b0, 23'h000010, -1, -1);

        // CAS_LATENCY=1, RECOVERY=0 instance, fully masked write
        enable2 = 1'b1; wr = 1'b1; adr = 23'h000020; dat_in = 16'h0000; dm = 2'b11;
        tick;
        enable2 = 1'b0; wr = 1'b0;
        check("fast_busy_rise", {31'd0, busy2}, 32'd1);
        check("fast_valid_low", {31'd0, valid2}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick;
            check("fast_valid_beat", {31'd0, valid2}, 32'd1);
            check("fast_busy_beat", {31'd0, busy2}, 32'd1);
        end
        tick;
        check("fast_valid_fall", {31'd0, valid2}, 32'd0);
        check("fast_busy_fall", {31'd0, busy2}, 32'd0);
        check("fast_dat_zero", {16'd0, dat_out2}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_burst_responder.md
Name: mem_burst_responder

Overview:
- Responder end of the memory-conduit command interface driven by the memory arbiter: accepts one rd/wr command and returns an 8-word burst.
- Backed by an internal on-chip word RAM with SDRAM-like timing: command acceptance via busy, programmable CAS latency, 8-cycle valid window, recovery.
- Used as the on-chip scratch/boot memory target and as the synthesizable stand-in for the SDRAM controller in arbiter bring-up.

Parameters:
ADDR_BITS, 10, internal RAM depth is 2^ADDR_BITS 16-bit words; adr_i[ADDR_BITS-1:0] used, upper bits ignored (aliasing)
CAS_LATENCY, 3, clock edges from command accept to first valid_o cycle; legal range 1..7
RECOVERY, 1, cycles busy_o stays high after burst end with valid_o low; legal range 0..7

Ports:
clock_i  in  1  sole clock; all logic on posedge
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  command strobe; sampled only in IDLE
rd_i  in  1  read command qualifier
wr_i  in  1  write command qualifier
adr_i  in  23  word address; latched at accept
dat_i  in  16  write data, sampled each valid_o cycle
dm_i  in  2  byte mask, 1 = byte not written; dm_i[0]->dat[7:0], dm_i[1]->dat[15:8]
busy_o  out  1  high from accept until end of recovery
valid_o  out  1  high for exactly 8 consecutive cycles per burst
dat_o  out  16  read data for current burst word; 0 when valid_o low or on writes

Behaviour:
- Reset (async assert): state IDLE; busy_o=0, valid_o=0, dat_o=0; counters and latched command cleared. RAM contents not cleared or modified. Release takes effect on next posedge.
- States: IDLE, LATENCY, BURST, RECOVER.
- IDLE: at posedge with enable_i & (rd_i | wr_i): latch adr_i, command (rd_i wins if both high), go LATENCY, busy_o=1 after that edge. enable_i with neither rd_i nor wr_i is ignored.
- LATENCY: counts so valid_o rises after edge E0+CAS_LATENCY, where E0 is the accept edge. CAS_LATENCY=1 means valid_o rises the cycle after busy_o rises.
- BURST: valid_o high exactly 8 cycles, word index k=0..7. Addresses wrap within the aligned 8-word block: word k at {adr[ADDR_BITS-1:3], adr[2:0]+k mod 8}.
  - Read: dat_o holds RAM[word k] during valid_o cycle k. Pre-fetch to hide RAM read latency. dat_o=0 outside valid_o.
  - Write: at each posedge with valid_o high, dat_i/dm_i are written to word k. Masked bytes are unchanged. Fully masked word (dm_i=2'b11) performs no write.
- RECOVER: valid_o=0, busy_o=1 for RECOVERY cycles, then IDLE with busy_o=0. RECOVERY=0 goes straight from BURST to IDLE.
- Next accept is possible on the first posedge where state is IDLE.
- enable_i, rd_i, wr_i, adr_i changes outside IDLE are ignored. No queuing, no abort.
- Reset mid-operation: burst aborted immediately. Writes already committed remain; remaining words are not written.
- Back-to-back: a command held high continuously is re-accepted once IDLE is reached. The requester must drop enable_i after seeing busy_o.

Test Plan:
- Write burst adr=0x000010, CAS=3, dat_i=0x1111..0x8888, dm=00 -> busy_o rises after E0, valid_o high edges E0+3..E0+10. Readback at 0x10 returns 0x1111..0x8888 in order; busy_o low after RECOVERY=1.
- Wrap: read adr=0x000015 after previous write -> dat_o sequence 0x6666,0x7777,0x8888,0x1111,0x2222,0x3333,0x4444,0x5555.
- Byte mask: write 0xABCD to word 0x10 with dm=2'b01 (over 0x1111) -> reads 0xAB11; with dm=2'b11 the word stays unchanged.
- rd_i=wr_i=1 at accept -> read performed, RAM unchanged. enable_i pulsed during BURST -> ignored, exactly 8 valid_o cycles. enable_i with rd_i=wr_i=0 -> busy_o stays 0.
- Aliasing/params: ADDR_BITS=10, write at 0x000400 then read 0x000000 -> same data. CAS_LATENCY=1, RECOVERY=0 -> valid_o one cycle after busy_o; busy_o falls with valid_o.
- Reset asserted during write word k=3 (async, mid-cycle) -> outputs 0 immediately. Words 0..2 written, 3..7 keep old data. New command accepted after reset release.
